// File: rtl/midi_param_bank.sv
// MIDI note/velocity driven parameter bank: absolute or toggle slots, with optional
// beat-synchronous staging, plus a one-shot broadcast of all values after reset.
//
// state   | meaning
// ST_INIT | broadcast active[k] for k = 0..NUM_PARAMS-1, events not accepted
// ST_RUN  | accept events, apply beat_tick commits
module midi_param_bank #(
  parameter int                    NUM_PARAMS  = 9,
  parameter int                    DATA_W      = 7,
  parameter int                    BASE_NOTE   = 20,
  parameter logic [NUM_PARAMS-1:0] TOGGLE_MASK = 9'b0_0000_0011,
  parameter logic [NUM_PARAMS-1:0] SYNC_MASK   = 9'b1_0000_0000,
  parameter int                    DEFAULT_VAL = 64,
  localparam int                   IDX_W       = $clog2(NUM_PARAMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   note,
  input  logic [6:0]                   velocity,
  input  logic                         beat_tick,
  output logic [NUM_PARAMS*DATA_W-1:0] params,
  output logic                         upd_valid,
  output logic [IDX_W-1:0]             upd_idx,
  output logic [DATA_W-1:0]            upd_value,
  output logic                         commit_valid,
  output logic [NUM_PARAMS-1:0]        commit_mask,
  output logic [NUM_PARAMS-1:0]        pending,
  output logic                         err_unmapped
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_active [NUM_PARAMS];
  logic [DATA_W-1:0]       r_shadow [NUM_PARAMS];
  logic [NUM_PARAMS-1:0]   r_pending;
  logic                    r_in_ready;
  logic                    r_upd_valid;
  logic [IDX_W-1:0]        r_upd_idx;
  logic [DATA_W-1:0]       r_upd_value;
  logic                    r_commit_valid;
  logic [NUM_PARAMS-1:0]   r_commit_mask;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_in_map;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_is_toggle;
  logic                    w_is_sync;
  logic                    w_vel_nz;
  logic [DATA_W-1:0]       w_act_flip;
  logic [DATA_W-1:0]       w_shd_flip;

  assign w_accept    = in_valid && r_in_ready;
  assign w_in_map    = ({1'b0, note} >= 8'(BASE_NOTE)) &&
                       ({1'b0, note} <  8'(BASE_NOTE + NUM_PARAMS));
  assign w_idx       = IDX_W'(note - 7'(BASE_NOTE));
  assign w_is_toggle = TOGGLE_MASK[w_idx];
  assign w_is_sync   = SYNC_MASK[w_idx];
  assign w_vel_nz    = (velocity != 7'd0);
  // Toggle slots only ever hold 0 or 1, so the flip rebuilds the whole word from bit 0.
  assign w_act_flip  = {{(DATA_W-1){1'b0}}, ~r_active[w_idx][0]};
  assign w_shd_flip  = {{(DATA_W-1){1'b0}}, ~r_shadow[w_idx][0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_INIT;
      r_cnt          <= '0;
      r_pending      <= '0;
      r_in_ready     <= 1'b0;
      r_upd_valid    <= 1'b0;
      r_upd_idx      <= '0;
      r_upd_value    <= '0;
      r_commit_valid <= 1'b0;
      r_commit_mask  <= '0;
      r_err          <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        r_active[i] <= TOGGLE_MASK[i] ? '0 : DATA_W'(DEFAULT_VAL);
        r_shadow[i] <= TOGGLE_MASK[i] ? '0 : DATA_W'(DEFAULT_VAL);
      end
    end else begin
      r_upd_valid    <= 1'b0;
      r_commit_valid <= 1'b0;
      r_err          <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_in_ready  <= 1'b0;
          r_upd_valid <= 1'b1;
          r_upd_idx   <= r_cnt;
          r_upd_value <= r_active[r_cnt];
          if (r_cnt == IDX_W'(NUM_PARAMS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_in_ready <= 1'b1;
          // Commit reads the pre-write shadow; a same-cycle event below re-arms its pending bit.
          if (beat_tick && (r_pending != '0)) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
              if (r_pending[i]) r_active[i] <= r_shadow[i];
            end
            r_commit_valid <= 1'b1;
            r_commit_mask  <= r_pending;
            r_pending      <= '0;
          end
          if (w_accept) begin
            if (!w_in_map) begin
              r_err <= 1'b1;
            end else if (w_is_sync) begin
              if (!w_is_toggle) begin
                r_shadow[w_idx]  <= velocity[DATA_W-1:0];
                r_pending[w_idx] <= 1'b1;
              end else if (w_vel_nz) begin
                r_shadow[w_idx]  <= w_shd_flip;
                r_pending[w_idx] <= 1'b1;
              end
            end else if (!w_is_toggle) begin
              r_active[w_idx] <= velocity[DATA_W-1:0];
              r_shadow[w_idx] <= velocity[DATA_W-1:0];
              r_upd_valid     <= 1'b1;
              r_upd_idx       <= w_idx;
              r_upd_value     <= velocity[DATA_W-1:0];
            end else if (w_vel_nz) begin
              r_active[w_idx] <= w_act_flip;
              r_shadow[w_idx] <= w_act_flip;
              r_upd_valid     <= 1'b1;
              r_upd_idx       <= w_idx;
              r_upd_value     <= w_act_flip;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_pack
    assign params[g*DATA_W +: DATA_W] = r_active[g];
  end

  assign in_ready     = r_in_ready;
  assign upd_valid    = r_upd_valid;
  assign upd_idx      = r_upd_idx;
  assign upd_value    = r_upd_value;
  assign commit_valid = r_commit_valid;
  assign commit_mask  = r_commit_mask;
  assign pending      = r_pending;
  assign err_unmapped = r_err;

endmodule

// File: tb/tb_midi_param_bank.sv
// Directed bench for midi_param_bank with default parameters (9 slots, 7-bit values).
module tb_midi_param_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  note = 7'd0;
  logic [6:0]  velocity = 7'd0;
  logic        beat_tick = 1'b0;
  logic [62:0] params;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic [6:0]  upd_value;
  logic        commit_valid;
  logic [8:0]  commit_mask;
  logic [8:0]  pending;
  logic        err_unmapped;

  int n_checks = 0;
  int n_errors = 0;
  int m [9];

  midi_param_bank dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .note(note), .velocity(velocity), .beat_tick(beat_tick), .params(params),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_value(upd_value),
    .commit_valid(commit_valid), .commit_mask(commit_mask), .pending(pending),
    .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [62:0] packed_model();
    logic [62:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*7 +: 7] = 7'(m[i]);
    return v;
  endfunction

  function automatic int slot(input int i);
    return int'(params[i*7 +: 7]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m[i] = (i < 2) ? 0 : 64;
  endtask

  task automatic send(input int n, input int v, input logic bt);
    in_valid  = 1'b1;
    note      = 7'(n);
    velocity  = 7'(v);
    beat_tick = bt;
    tick();
    in_valid  = 1'b0;
    beat_tick = 1'b0;
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
  endtask

  task automatic broadcast(input string tag, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      tick();
      check({tag, "_upd_valid"}, 64'(upd_valid), 64'd1);
      check({tag, "_upd_idx"},   64'(upd_idx),   64'(k));
      check({tag, "_upd_value"}, 64'(upd_value), (k < 2) ? 64'd0 : 64'd64);
      check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    end
  endtask

  initial begin
    model_reset();
    in_valid = 1'b1;
    note     = 7'd24;
    velocity = 7'd100;
    tick();
    tick();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_upd_valid", 64'(upd_valid), 64'd0);
    check("rst_upd_idx",   64'(upd_idx),   64'd0);
    check("rst_pending",   64'(pending),   64'd0);
    check("rst_params",    64'(params),    64'(packed_model()));

    rst = 1'b0;
    broadcast("init", 8);
    tick();
    check("run_in_ready",    64'(in_ready),  64'd1);
    check("init_no_accept",  64'(slot(4)),   64'd64);
    check("run_first_noupd", 64'(upd_valid), 64'd0);
    in_valid = 1'b0;

    send(24, 100, 1'b0);
    m[4] = 100;
    check("abs_upd_valid", 64'(upd_valid), 64'd1);
    check("abs_upd_idx",   64'(upd_idx),   64'd4);
    check("abs_upd_value", 64'(upd_value), 64'd100);
    check("abs_slot4",     64'(slot(4)),   64'd100);
    tick();
    check("abs_pulse_one", 64'(upd_valid), 64'd0);
    send(24, 100, 1'b0);
    check("abs_repeat_pulse", 64'(upd_valid), 64'd1);
    check("abs_repeat_value", 64'(upd_value), 64'd100);

    send(20, 90, 1'b0);
    m[0] = 1;
    check("tog_on_slot0",  64'(slot(0)),   64'd1);
    check("tog_on_upd",    64'(upd_valid), 64'd1);
    check("tog_on_value",  64'(upd_value), 64'd1);
    send(20, 0, 1'b0);
    check("tog_off_slot0", 64'(slot(0)),      64'd1);
    check("tog_off_noupd", 64'(upd_valid),    64'd0);
    check("tog_off_noerr", 64'(err_unmapped), 64'd0);
    send(20, 5, 1'b0);
    m[0] = 0;
    check("tog_flip_slot0", 64'(slot(0)),   64'd0);
    check("tog_flip_value", 64'(upd_value), 64'd0);

    send(28, 120, 1'b0);
    check("sync_pending", 64'(pending),   64'h100);
    check("sync_slot8",   64'(slot(8)),   64'd64);
    check("sync_noupd",   64'(upd_valid), 64'd0);
    beat();
    m[8] = 120;
    check("commit_slot8",   64'(slot(8)),      64'd120);
    check("commit_valid",   64'(commit_valid), 64'd1);
    check("commit_mask",    64'(commit_mask),  64'h100);
    check("commit_pending", 64'(pending),      64'd0);

    send(28, 120, 1'b0);
    send(28, 30, 1'b1);
    check("coll_slot8",   64'(slot(8)),      64'd120);
    check("coll_pending", 64'(pending),      64'h100);
    check("coll_commit",  64'(commit_valid), 64'd1);
    beat();
    m[8] = 30;
    check("coll_next_slot8", 64'(slot(8)), 64'd30);

    send(28, 11, 1'b0);
    send(28, 50, 1'b0);
    send(25, 33, 1'b1);
    m[8] = 50;
    m[5] = 33;
    check("both_upd_idx",   64'(upd_idx),      64'd5);
    check("both_upd_value", 64'(upd_value),    64'd33);
    check("both_commit",    64'(commit_valid), 64'd1);
    check("both_lastwins",  64'(slot(8)),      64'd50);
    check("both_pending",   64'(pending),      64'd0);
    beat();
    check("empty_beat", 64'(commit_valid), 64'd0);

    send(19, 77, 1'b0);
    check("unmap_lo_err",    64'(err_unmapped), 64'd1);
    check("unmap_lo_params", 64'(params),       64'(packed_model()));
    send(29, 77, 1'b0);
    check("unmap_hi_err",    64'(err_unmapped), 64'd1);
    check("unmap_hi_params", 64'(params),       64'(packed_model()));
    check("unmap_hi_noupd",  64'(upd_valid),    64'd0);
    tick();
    check("unmap_pulse_one", 64'(err_unmapped), 64'd0);

    send(28, 99, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_params",  64'(params),  64'(packed_model()));
    tick();
    rst = 1'b0;
    broadcast("bc_a", 4);
    rst = 1'b1;
    tick();
    check("abort_upd_valid", 64'(upd_valid), 64'd0);
    rst = 1'b0;
    broadcast("bc_b", 8);
    tick();
    check("re_run_in_ready", 64'(in_ready), 64'd1);
    beat();
    check("shadow_dropped_commit", 64'(commit_valid), 64'd0);
    check("shadow_dropped_slot8",  64'(slot(8)),      64'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/midi_param_bank.md
Name: midi_param_bank

Overview:
- Parametrised MIDI-controlled parameter register bank in the decoder path, between the MIDI note/velocity parser and the synth/arpeggiator consumers.
- Maps a note number to a parameter slot. Per slot, the accepted event either stores velocity (absolute slot) or flips an enable (toggle slot).
- Slots flagged as beat-synchronous are staged in a shadow register and applied on a beat tick.
- After reset, it broadcasts every parameter value once so downstream copies start coherent.

Parameters:
- NUM_PARAMS, 9, number of slots (2..16).
- DATA_W, 7, parameter width.
- BASE_NOTE, 20, note mapped to slot 0; slot i = note BASE_NOTE+i.
- TOGGLE_MASK, 9'b0_0000_0011, bit i=1: slot i is a toggle.
- SYNC_MASK, 9'b1_0000_0000, bit i=1: slot i is committed only on beat_tick.
- DEFAULT_VAL, 64, reset value of absolute slots (toggle slots reset to 0).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  note/velocity event valid
- in_ready  out  1  bank accepts event; transfer when in_valid&&in_ready
- note  in  7  MIDI note number
- velocity  in  7  MIDI velocity
- beat_tick  in  1  one-cycle pulse from tempo clock; commits pending sync slots
- params  out  NUM_PARAMS*DATA_W  active values, slot i at [i*DATA_W +: DATA_W]
- upd_valid  out  1  one-cycle pulse: upd_idx/upd_value changed or broadcast
- upd_idx  out  IDX_W  slot index, IDX_W=$clog2(NUM_PARAMS)
- upd_value  out  DATA_W  new active value of upd_idx
- commit_valid  out  1  one-cycle pulse: pending sync slots applied
- commit_mask  out  NUM_PARAMS  slots applied by that commit
- pending  out  NUM_PARAMS  shadow holds an uncommitted value
- err_unmapped  out  1  one-cycle pulse: accepted note outside the map

Behaviour:
- Async reset values:
  - Absolute slots = DEFAULT_VAL; toggle slots = 0; shadows = active values.
  - pending=0; all pulses 0; upd_idx=0; upd_value=0; in_ready=0; FSM=INIT, counter=0.
- FSM INIT (NUM_PARAMS cycles after rst falls):
  - Cycle k: upd_valid=1, upd_idx=k, upd_value=active[k].
  - in_ready=0; beat_tick ignored.
  - After k=NUM_PARAMS-1, go to RUN.
- FSM RUN: in_ready=1 every cycle. No other state; rst re-enters INIT from any point.
- Mapping:
  - idx = note-BASE_NOTE, valid iff BASE_NOTE <= note <= BASE_NOTE+NUM_PARAMS-1.
  - Unmapped accepted event: err_unmapped pulses next cycle; no state change.
- Absolute slot, accepted at cycle T:
  - Immediate slot: active[idx] <= velocity; upd_valid/idx/value at T+1, value = velocity.
  - Every accepted event pulses, including an unchanged value.
- Toggle slot:
  - velocity!=0: bit0 flips (value 0<->1), upper bits stay 0.
  - velocity==0 (note-off): ignored; no pulse, no error.
- Sync slot (SYNC_MASK bit set):
  - Write goes to shadow[idx]; pending[idx] set at T+1; no upd_valid.
  - Toggle+sync slots flip the shadow.
- beat_tick in RUN with pending!=0:
  - active[i] <= shadow[i] for all pending i.
  - Next cycle: commit_valid=1, commit_mask=old pending; pending cleared.
  - beat_tick with pending==0: no pulse.
- Simultaneous event and beat_tick on the same sync slot:
  - Commit uses the shadow value before the write; the incoming write lands in shadow.
  - pending[idx] stays 1 for the next tick.
  - On other slots, both operations complete in the same cycle.
- Repeated writes to one sync slot before a tick: last write wins.
- Reset mid-operation:
  - All shadows and pending are discarded.
  - An INIT broadcast that has not finished is aborted and restarts at 0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Release rst; hold in_valid=1 -> in_ready=0 for 9 cycles; upd_valid pulses idx 0..8 with values 0,0,64×7; in_ready=1 on cycle 10; nothing accepted during INIT.
- RUN: note=24, vel=100 -> next cycle upd_idx=4, upd_value=100, params slot4=100; note=24, vel=100 again -> pulse repeats.
- note=20, vel=90 -> slot0=1; note=20, vel=0 -> no change, no pulse; note=20, vel=5 -> slot0=0.
- note=28 (slot 8 sync), vel=120 -> pending[8]=1, slot8 still 64, no upd_valid; beat_tick -> slot8=120, commit_valid, commit_mask=9'h100, pending=0.
- Pending slot8=120 with note=28, vel=30 and beat_tick in the same cycle -> slot8=120, pending[8]=1; next beat_tick -> slot8=30.
- note=19 and note=29 -> err_unmapped pulses, params unchanged. rst asserted at INIT k=4 -> after release the broadcast restarts at idx 0.
